// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word valid/ready holding register.
// Latency: 1 cycle from the final qualified bit to data_valid. Backpressure: a word that completes while the holder is full is dropped and overrun pulses.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN (parity_err is tied low otherwise).
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
`ifdef SIPO_PARITY_EN
    localparam int LEN      = WIDTH + 1,
`else
    localparam int LEN      = WIDTH,
`endif
    localparam int CW       = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_count,
    output logic             parity_err
);

    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] seeded;
    logic [WIDTH-1:0] word;
    logic             word_par_err;
    logic             complete;
    logic             free;

    always_comb begin
        shifted = MSB_FIRST ? {shreg[WIDTH-2:0], bit_in} : {bit_in, shreg[WIDTH-1:1]};
        seeded  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_in} : {bit_in, {(WIDTH-1){1'b0}}};
        // A resync bit is always bit 0, so it can never complete a word.
        complete = bit_en && !frame_start && (bit_count == LAST);
        free     = !data_valid || data_ready;
`ifdef SIPO_PARITY_EN
        word         = shreg;
        word_par_err = ^{shreg, bit_in};
`else
        word         = shifted;
        word_par_err = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (frame_start) begin
                shreg     <= bit_en ? seeded : '0;
                bit_count <= bit_en ? CW'(1) : '0;
            end else if (bit_en) begin
                if (complete) begin
                    bit_count <= '0;
`ifndef SIPO_PARITY_EN
                    shreg     <= shifted;
`endif
                end else begin
                    bit_count <= bit_count + CW'(1);
                    shreg     <= shifted;
                end
            end

            if (complete) begin
                if (free) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (complete && free) begin
            parity_err <= word_par_err;
        end
    end
`else
    assign parity_err = 1'b0;
    logic unused_par;
    assign unused_par = word_par_err;
`endif

endmodule
